// File: rtl/featuremap_pad_writer.sv
// Producer for one channel FIFO: takes an unpadded WIDTH x HEIGHT raster stream and
// writes the zero-padded (WIDTH+2) x (HEIGHT+2) raster, one word per issued write.
module featuremap_pad_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 56,
   parameter int HEIGHT     = 56
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_in,
   input  logic                  fifo_almost_full,
   output logic                  wrreq,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam int RW = $clog2(HEIGHT + 2);

   localparam logic [CW-1:0] C_ONE      = CW'(1);
   localparam logic [CW-1:0] C_LAST_INT = CW'(WIDTH);
   localparam logic [CW-1:0] C_LAST     = CW'(WIDTH + 1);
   localparam logic [RW-1:0] R_ONE      = RW'(1);
   localparam logic [RW-1:0] R_LAST_INT = RW'(HEIGHT);
   localparam logic [RW-1:0] R_LAST     = RW'(HEIGHT + 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         c_cnt_q;
   logic [CW-1:0]         c_cnt_d;
   logic [RW-1:0]         r_cnt_q;
   logic [RW-1:0]         r_cnt_d;
   logic                  interior_s;
   logic                  last_slot_s;
   logic                  fire_s;
   logic [DATA_WIDTH-1:0] slot_data_s;

   // Slot classification, write-issue decision and next raster position
   always_comb begin
      interior_s  = (r_cnt_q >= R_ONE) && (r_cnt_q <= R_LAST_INT) &&
                    (c_cnt_q >= C_ONE) && (c_cnt_q <= C_LAST_INT);
      last_slot_s = (r_cnt_q == R_LAST) && (c_cnt_q == C_LAST);

      fire_s = 1'b0;
      if ((state_q == S_RUN) && !fifo_almost_full) begin
         if (interior_s) begin
            fire_s = valid_in;
         end else begin
            fire_s = 1'b1;
         end
      end else begin
         fire_s = 1'b0;
      end

      ready_in = (state_q == S_RUN) && interior_s && !fifo_almost_full;

      if (interior_s) begin
         slot_data_s = data_in;
      end else begin
         slot_data_s = {DATA_WIDTH{1'b0}};
      end

      // Column wraps into the next row; the row wraps at end of frame
      if (c_cnt_q == C_LAST) begin
         c_cnt_d = {CW{1'b0}};
         if (r_cnt_q == R_LAST) begin
            r_cnt_d = {RW{1'b0}};
         end else begin
            r_cnt_d = r_cnt_q + R_ONE;
         end
      end else begin
         c_cnt_d = c_cnt_q + C_ONE;
         r_cnt_d = r_cnt_q;
      end
   end

   // Frame FSM with raster counters and registered FIFO write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         c_cnt_q    <= {CW{1'b0}};
         r_cnt_q    <= {RW{1'b0}};
         wrreq      <= 1'b0;
         data_out   <= {DATA_WIDTH{1'b0}};
         frame_done <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               wrreq      <= 1'b0;
               frame_done <= 1'b0;
               c_cnt_q    <= {CW{1'b0}};
               r_cnt_q    <= {RW{1'b0}};
               if (valid_in) begin
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (fire_s) begin
                  wrreq      <= 1'b1;
                  data_out   <= slot_data_s;
                  frame_done <= last_slot_s;
                  c_cnt_q    <= c_cnt_d;
                  r_cnt_q    <= r_cnt_d;
                  if (last_slot_s) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_RUN;
                  end
               end else begin
                  wrreq      <= 1'b0;
                  frame_done <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               c_cnt_q    <= {CW{1'b0}};
               r_cnt_q    <= {RW{1'b0}};
               wrreq      <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Directed bench for featuremap_pad_writer: a 4x3 instance for the functional cases
// and a default 56x56 instance for the full-size throughput case.
module tb_featuremap_pad_writer;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int PW    = W + 2;
   localparam int PH    = H + 2;
   localparam int NSLOT = PW * PH;
   localparam int BPW   = 58;
   localparam int BNSL  = 58 * 58;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_in;
   logic        fifo_almost_full;
   logic        wrreq;
   logic [31:0] data_out;
   logic        frame_done;

   logic [31:0] b_data_in;
   logic        b_valid_in;
   logic        b_ready_in;
   logic        b_afull;
   logic        b_wrreq;
   logic [31:0] b_data_out;
   logic        b_frame_done;

   always #5 clk = ~clk;

   featuremap_pad_writer #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
      .fifo_almost_full(fifo_almost_full), .wrreq(wrreq), .data_out(data_out),
      .frame_done(frame_done)
   );

   featuremap_pad_writer u_big (
      .clk(clk), .rst(rst), .data_in(b_data_in), .valid_in(b_valid_in), .ready_in(b_ready_in),
      .fifo_almost_full(b_afull), .wrreq(b_wrreq), .data_out(b_data_out),
      .frame_done(b_frame_done)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] in_q[$];
   logic [31:0] wr_q[$];
   bit          fd_q[$];
   int          n_acc, frames, fd_cnt, fw, timeouts;
   int          pad_rdy_viol, afull_rdy_viol, bp_viol, bp_gap, pad_delay;
   bit          prev_afull, pend_pad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic bit is_pad(input int s);
      int r, c;
      r = s / PW;
      c = s % PW;
      return (r == 0) || (r >= PH - 1) || (c == 0) || (c == PW - 1);
   endfunction

   function automatic logic [31:0] exp_word(input int s, input logic [31:0] base);
      int r, c;
      r = s / PW;
      c = s % PW;
      if (is_pad(s)) return 32'h0;
      return base + 32'((r - 1) * W + (c - 1));
   endfunction

   function automatic logic [31:0] big_word(input int s);
      int r, c;
      r = s / BPW;
      c = s % BPW;
      if (r == 0 || r == BPW - 1 || c == 0 || c == BPW - 1) return 32'h0;
      return 32'h1000 + 32'((r - 1) * 56 + (c - 1));
   endfunction

   // one negedge observation of the small instance
   task automatic sample();
      int s;
      @(negedge clk);
      if (wrreq) begin
         wr_q.push_back(data_out);
         fd_q.push_back(frame_done);
         fw++;
      end
      if (frame_done) fd_cnt++;
      if (wrreq && frame_done) begin
         frames++;
         fw = 0;
      end
      if (prev_afull && wrreq) bp_viol++;
      if (prev_afull && !wrreq) bp_gap++;
      if (pend_pad && !wrreq) pad_delay++;
      s = fw;
      if (is_pad(s) && ready_in) pad_rdy_viol++;
      if (fifo_almost_full && ready_in) afull_rdy_viol++;
      pend_pad   = is_pad(s) && (fw > 0) && !fifo_almost_full;
      prev_afull = fifo_almost_full;
      if (valid_in && ready_in) n_acc++;
   endtask

   task automatic run(input int n_frames, input bit toggle, input int stall_at,
                      input int stall_len, input int abort_at, input int budget);
      int cyc, stall_left;
      bit stall_done, stop;
      cyc = 0; stall_left = 0; stall_done = 1'b0; stop = 1'b0;
      wr_q.delete(); fd_q.delete();
      n_acc = 0; frames = 0; fd_cnt = 0; fw = 0; timeouts = 0;
      pad_rdy_viol = 0; afull_rdy_viol = 0; bp_viol = 0; bp_gap = 0; pad_delay = 0;
      prev_afull = 1'b0; pend_pad = 1'b0;
      while (!stop) begin
         valid_in = (n_acc < in_q.size()) && (!toggle || (cyc % 2 == 0));
         data_in  = (n_acc < in_q.size()) ? in_q[n_acc] : 32'h0;
         if (!stall_done && stall_at >= 0 && wr_q.size() == stall_at) begin
            stall_left = stall_len;
            stall_done = 1'b1;
         end
         fifo_almost_full = (stall_left > 0);
         if (stall_left > 0) stall_left--;
         sample();
         cyc++;
         if (frames >= n_frames || (abort_at >= 0 && wr_q.size() >= abort_at)) begin
            stop = 1'b1;
         end else if (cyc >= budget) begin
            stop = 1'b1;
            timeouts++;
         end else begin
            @(posedge clk);
            #2;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         valid_in = 1'b0;
         fifo_almost_full = 1'b0;
         sample();
      end
   endtask

   task automatic check_seq(input string tag, input int nf, input logic [31:0] b1,
                            input logic [31:0] b2);
      int n;
      chk({tag, " timeout"}, timeouts, 0);
      chk({tag, " writes"}, wr_q.size(), nf * NSLOT);
      chk({tag, " frame_done pulses"}, fd_cnt, nf);
      chk({tag, " inputs accepted"}, n_acc, nf * W * H);
      n = (wr_q.size() < nf * NSLOT) ? wr_q.size() : nf * NSLOT;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s word %0d", tag, i), wr_q[i],
             exp_word(i % NSLOT, (i < NSLOT) ? b1 : b2));
         chk($sformatf("%s frame_done@%0d", tag, i), 32'(fd_q[i]),
             (i % NSLOT == NSLOT - 1) ? 32'd1 : 32'd0);
      end
      chk({tag, " ready on pad"}, pad_rdy_viol, 0);
   endtask

   int          b_wr, b_acc, b_fd, b_mis, b_first, b_last;
   logic [31:0] b_w59;
   bit          b_done;

   initial begin
      rst = 1'b1;
      valid_in = 1'b0; data_in = 32'h0; fifo_almost_full = 1'b0;
      b_valid_in = 1'b0; b_data_in = 32'h0; b_afull = 1'b0;
      #12;
      chk("reset wrreq", 32'(wrreq), 32'd0);
      chk("reset data_out", data_out, 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset ready_in", 32'(ready_in), 32'd0);
      chk("reset big wrreq", 32'(b_wrreq), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #2;

      // single frame, continuous input 1..12
      in_q.delete();
      for (int i = 1; i <= 12; i++) in_q.push_back(32'(i));
      run(1, 1'b0, -1, 0, -1, 200);
      idle_cycles(3);
      check_seq("t1", 1, 32'd1, 32'd0);

      // valid_in toggling every cycle
      run(1, 1'b1, -1, 0, -1, 200);
      idle_cycles(3);
      check_seq("t2", 1, 32'd1, 32'd0);
      chk("t2 pad delayed", pad_delay, 0);

      // almost-full for 5 cycles in the middle of row 2
      run(1, 1'b0, 14, 5, -1, 200);
      idle_cycles(3);
      check_seq("t3", 1, 32'd1, 32'd0);
      chk("t3 write under almost_full", bp_viol, 0);
      chk("t3 stalled cycles", bp_gap, 5);
      chk("t3 ready under almost_full", afull_rdy_viol, 0);

      // two frames back to back
      in_q.delete();
      for (int i = 1; i <= 12; i++) in_q.push_back(32'(i));
      for (int i = 101; i <= 112; i++) in_q.push_back(32'(i));
      run(2, 1'b0, -1, 0, -1, 300);
      idle_cycles(3);
      check_seq("t4", 2, 32'd1, 32'd101);

      // asynchronous reset after write 14, then a clean frame
      in_q.delete();
      for (int i = 1; i <= 12; i++) in_q.push_back(32'(i));
      run(1, 1'b0, -1, 0, 14, 200);
      chk("t5 writes before abort", wr_q.size(), 14);
      chk("t5 data before abort", data_out, 32'd5);
      chk("t5 ready before abort", 32'(ready_in), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("t5 wrreq in reset", 32'(wrreq), 32'd0);
      chk("t5 data_out in reset", data_out, 32'd0);
      chk("t5 frame_done in reset", 32'(frame_done), 32'd0);
      chk("t5 ready_in in reset", 32'(ready_in), 32'd0);
      #1 rst = 1'b0;
      @(posedge clk);
      #2;
      run(1, 1'b0, -1, 0, -1, 200);
      idle_cycles(3);
      check_seq("t5", 1, 32'd1, 32'd0);

      // default 56x56 instance, continuous input
      valid_in = 1'b0;
      b_wr = 0; b_acc = 0; b_fd = 0; b_mis = 0; b_first = -1; b_last = -1;
      b_w59 = 32'hFFFF_FFFF; b_done = 1'b0;
      for (int cyc = 0; cyc < 4000 && !b_done; cyc++) begin
         b_valid_in = (b_acc < 3136);
         b_data_in  = 32'h1000 + 32'(b_acc);
         @(negedge clk);
         if (b_wrreq) begin
            if (b_wr == 0) b_first = cyc;
            b_last = cyc;
            if (b_data_out !== big_word(b_wr)) b_mis++;
            if (b_wr == 59) b_w59 = b_data_out;
            if (b_frame_done) b_done = 1'b1;
            b_wr++;
         end
         if (b_frame_done) b_fd++;
         if (b_valid_in && b_ready_in) b_acc++;
         if (!b_done) begin
            @(posedge clk);
            #2;
         end
      end
      chk("big frame completed", 32'(b_done), 32'd1);
      chk("big writes", b_wr, BNSL);
      chk("big write span", b_last - b_first + 1, BNSL);
      chk("big inputs accepted", b_acc, 3136);
      chk("big first interior write", b_w59, 32'h1000);
      chk("big word errors", b_mis, 0);
      chk("big frame_done pulses", b_fd, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/featuremap_pad_writer.md
# featuremap_pad_writer

Producer side of the per-channel feature-map FIFOs that feed `conv2D` and the `featuremap_conv2d_*` filter blocks. It accepts an unpadded WIDTH×HEIGHT feature map in raster order over a valid/ready stream. It writes the zero-padded (WIDTH+2)×(HEIGHT+2) map into one channel FIFO in raster order, which is the layout the downstream conv2D line buffers (configured with WIDTH+2) expect. One instance is used per channel, so a 16-channel layer uses 16 instances.

## Interface
Parameters:
- DATA_WIDTH, 32, word width (IEEE-754 single).
- WIDTH, 56, unpadded feature-map width in pixels.
- HEIGHT, 56, unpadded feature-map height in pixels.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  DATA_WIDTH  input pixel.
- valid_in  in  1  data_in is valid.
- ready_in  out  1  block accepts data_in this cycle.
- fifo_almost_full  in  1  FIFO has at most one free word; no write may be issued while this is high.
- wrreq  out  1  FIFO write strobe (registered).
- data_out  out  DATA_WIDTH  FIFO write data (registered).
- frame_done  out  1  one-cycle pulse coincident with the last write of a frame.

## Operation
- Padded frame coordinates:
  - row r in 0..HEIGHT+1, col c in 0..WIDTH+1.
  - The slot is interior if 1≤r≤HEIGHT and 1≤c≤WIDTH; otherwise it is pad.
- Counters:
  - r_cnt and c_cnt, each clog2(max+2) bits wide.
  - c_cnt wraps from WIDTH+1 to 0 and increments r_cnt.
  - r_cnt wraps from HEIGHT+1 to 0 at end of frame.
  - Both counters advance only on an issued write.
- FSM:
  - IDLE: counters at 0. Moves to RUN when valid_in=1. No write is issued in the transition cycle.
  - RUN: emits slots in raster order. After issuing the write for (HEIGHT+1, WIDTH+1), moves to IDLE.
- Write issue in RUN (the "fire" condition):
  - Pad slot: fire = !fifo_almost_full; write data is 32'h0000_0000 (+0.0).
  - Interior slot: fire = valid_in && !fifo_almost_full; write data is data_in.
- ready_in is combinational: (state==RUN) && interior && !fifo_almost_full. An input beat transfers when valid_in && ready_in.
- Pad slots never consume input. Input is stalled (ready_in=0) during pad slots and while the FIFO is almost full.
- Output registers:
  - On fire: wrreq<=1, data_out<=slot data.
  - Otherwise: wrreq<=0, data_out holds its last value.
- frame_done<=1 on the cycle the last slot fires, else 0.
- Each frame writes exactly (WIDTH+2)(HEIGHT+2) words: 3364 for the defaults. Each frame consumes exactly WIDTH×HEIGHT inputs: 3136 for the defaults.
- Frames are back-to-back: the next frame starts from IDLE on the next valid_in.

## Timing
- Reset value of every output: wrreq=0, data_out=0, frame_done=0, ready_in=0. FSM is in IDLE and counters are 0.
- Latency: an accepted input beat appears on data_out with wrreq=1 one cycle after acceptance.
- Throughput: one word per cycle when the FIFO is not almost full. A full frame with no backpressure takes (W+2)(H+2) cycles after the IDLE→RUN cycle.
- Backpressure: fifo_almost_full sampled high means no write is issued in the following cycle. The one-word FIFO margin absorbs the write already registered.
- Simultaneous events:
  - If valid_in=0 on an interior slot, the block stalls and the counters hold.
  - Pad slots proceed regardless of valid_in.
- Wrap-around: the last pad slot's write and frame_done occur in the same cycle. The counters return to 0 and the state to IDLE in that cycle.
- Reset mid-frame: the frame is aborted immediately (asynchronously). The counters and outputs return to their reset values, and the partial frame is not completed.

## Test plan
- W=4, H=3, valid_in held at 1, FIFO never full, inputs 1..12:
  - exactly 30 writes;
  - writes 0–5 are 0;
  - row 1 is 0,1,2,3,4,0;
  - the last 6 writes are 0;
  - frame_done fires on write 30 only.
- Same configuration, valid_in toggled 1/0 every cycle:
  - identical write sequence;
  - pad slots are never delayed by valid_in=0;
  - ready_in stays 0 on every pad slot.
- fifo_almost_full held high for 5 cycles mid-row 2:
  - no wrreq for those 5 cycles;
  - ready_in=0 throughout;
  - no data lost or duplicated;
  - final sequence equals the no-stall case.
- Two frames back-to-back (inputs 1..12, then 101..112):
  - 60 writes total;
  - the second frame starts with 6 zeros;
  - frame_done pulses twice.
- rst asserted asynchronously after write 14:
  - outputs are 0 immediately, ready_in=0;
  - the next frame restarts at slot (0,0) with 30 clean writes.
- Default parameters (56×56), continuous input:
  - 3364 writes in 3364 consecutive cycles;
  - 3136 inputs accepted;
  - the first interior write is input 0 at write index 59.
